tlul_sram_resp: RTL and testbench

// - TL-UL device-side SRAM responder; sits directly downstream of spi_device_tlul, consuming its tl_h2d requests.
// - Accepts Get / PutFullData / PutPartialData and drives a single-port SRAM macro (1-cycle read latency).
// - Returns AccessAck / AccessAckData through a small response buffer, so d_ready back-pressure never drops data.

---
 rtl/tlul_sram_resp_pkg.sv | 63 ++++++
 rtl/tlul_sram_resp_fifo.sv | 57 +++++
 rtl/tlul_sram_resp.sv | 140 ++++++++++++++
 tb/tb_tlul_sram_resp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_sram_resp_pkg.sv
// Shared types for the TL-UL SRAM responder: bus structs, response entry and opcode constants.
package tlul_sram_resp_pkg;

  localparam int DataW  = 32;
  localparam int MaskW  = DataW / 8;
  localparam int SrcW   = 8;
  localparam int SizeW  = 2;
  localparam int UserW  = 8;

  // A-channel opcodes
  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpGet            = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] OpAccessAck      = 3'd0;
  localparam logic [2:0] OpAccessAckData  = 3'd1;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [SizeW-1:0] a_size;
    logic [SrcW-1:0]  a_source;
    logic [31:0]      a_address;
    logic [MaskW-1:0] a_mask;
    logic [DataW-1:0] a_data;
    logic [UserW-1:0] a_user;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [SizeW-1:0] d_size;
    logic [SrcW-1:0]  d_source;
    logic [0:0]       d_sink;
    logic [DataW-1:0] d_data;
    logic [UserW-1:0] d_user;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [SizeW-1:0] size;
    logic [SrcW-1:0]  source;
    logic [DataW-1:0] data;
    logic             error;
  } resp_entry_t;

  // Byte i of the TL-UL mask becomes bits [8i+7:8i] of the SRAM bit mask.
  function automatic logic [DataW-1:0] expandMask(input logic [MaskW-1:0] mask);
    logic [DataW-1:0] bits;
    bits = '0;
    for (int i = 0; i < MaskW; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/tlul_sram_resp_fifo.sv
// Small synchronous FIFO holding pending D-channel responses, with an occupancy count.
module tlul_sram_resp_fifo
  import tlul_sram_resp_pkg::*;
#(
  parameter int Depth = 2,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic            i_clk,
  input  logic            i_rstN,
  input  logic            i_push,
  input  resp_entry_t     i_entry,
  input  logic            i_pop,
  output resp_entry_t     o_head,
  output logic [CntW-1:0] o_count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  resp_entry_t     r_mem [Depth];
  logic [PtrW-1:0] r_wrPtr;
  logic [PtrW-1:0] r_rdPtr;
  logic [CntW-1:0] r_count;

  logic w_doPush;
  logic w_doPop;

  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count != FullCnt) || w_doPop);

  // Pointer and count bookkeeping; pointers wrap at the last entry, so any depth works.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= (r_wrPtr == LastPtr) ? '0 : r_wrPtr + PtrW'(1);
      if (w_doPop)  r_rdPtr <= (r_rdPtr == LastPtr) ? '0 : r_rdPtr + PtrW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_entry;
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/tlul_sram_resp.sv
// TL-UL device-side SRAM responder: accepts Get/PutFullData/PutPartialData, drives a
// 1-cycle-latency single-port SRAM and returns responses through a small buffer.
// Optional build macro TLUL_SRAM_RESP_RANGE_ERR_EN: out-of-range or misaligned addresses
// get an error response with no SRAM access instead of aliasing.
module tlul_sram_resp
  import tlul_sram_resp_pkg::*;
#(
  parameter int Depth     = 1024,
  parameter int AddrWidth = $clog2(Depth),
  parameter int RespDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  tl_h2d_t              tl_i,
  output tl_d2h_t              tl_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataW-1:0]     wdata_o,
  output logic [DataW-1:0]     wmask_o,
  input  logic [DataW-1:0]     rdata_i
);

  localparam int CntW = $clog2(RespDepth + 1);

  logic             r_ready;
  logic             r_inflight;
  logic [2:0]       r_infOpcode;
  logic [SizeW-1:0] r_infSize;
  logic [SrcW-1:0]  r_infSource;
  logic             r_infError;
  logic             r_infUseRdata;
  logic [DataW-1:0] r_infFixedData;

  logic             w_aReady;
  logic             w_accept;
  logic             w_isGet;
  logic             w_isPut;
  logic             w_validOp;
  logic             w_rangeErr;
  logic             w_sramAccess;
  logic [CntW-1:0]  w_count;
  logic [CntW:0]    w_occupancy;
  logic             w_dValid;
  logic             w_pop;
  resp_entry_t      w_pushEntry;
  resp_entry_t      w_head;
  logic             w_unused;

  assign w_isGet   = (tl_i.a_opcode == OpGet);
  assign w_isPut   = (tl_i.a_opcode == OpPutFullData) || (tl_i.a_opcode == OpPutPartialData);
  assign w_validOp = w_isGet || w_isPut;

`ifdef TLUL_SRAM_RESP_RANGE_ERR_EN
  assign w_rangeErr = (|tl_i.a_address[31:AddrWidth+2]) || (|tl_i.a_address[1:0]);
`else
  assign w_rangeErr = 1'b0;
`endif

  // Counting the in-flight access as occupied guarantees its response always has a slot.
  assign w_occupancy = {1'b0, w_count} + {{CntW{1'b0}}, r_inflight};
  assign w_aReady    = r_ready && (w_occupancy < (CntW+1)'(RespDepth));
  assign w_accept    = tl_i.a_valid && w_aReady;

  assign w_sramAccess = w_accept && w_validOp && !w_rangeErr;
  assign req_o        = w_sramAccess;
  assign we_o         = w_sramAccess && !w_isGet;
  assign addr_o       = tl_i.a_address[AddrWidth+1:2];
  assign wdata_o      = tl_i.a_data;
  assign wmask_o      = expandMask(tl_i.a_mask);

  assign w_unused = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[31:AddrWidth+2],
                      tl_i.a_address[1:0]};

  // Remember what was accepted so the response can be built once SRAM read data arrives.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ready        <= 1'b0;
      r_inflight     <= 1'b0;
      r_infOpcode    <= '0;
      r_infSize      <= '0;
      r_infSource    <= '0;
      r_infError     <= 1'b0;
      r_infUseRdata  <= 1'b0;
      r_infFixedData <= '0;
    end else begin
      r_ready    <= 1'b1;
      r_inflight <= w_accept;
      if (w_accept) begin
        r_infOpcode    <= w_isGet ? OpAccessAckData : OpAccessAck;
        r_infSize      <= tl_i.a_size;
        r_infSource    <= tl_i.a_source;
        r_infError     <= !w_validOp || w_rangeErr;
        r_infUseRdata  <= w_isGet && !w_rangeErr;
        r_infFixedData <= (w_isGet && w_rangeErr) ? '1 : '0;
      end
    end
  end

  // Assemble the response entry pushed in the cycle after accept.
  always_comb begin
    w_pushEntry        = '0;
    w_pushEntry.opcode = r_infOpcode;
    w_pushEntry.size   = r_infSize;
    w_pushEntry.source = r_infSource;
    w_pushEntry.data   = r_infUseRdata ? rdata_i : r_infFixedData;
    w_pushEntry.error  = r_infError;
  end

  tlul_sram_resp_fifo #(
    .Depth (RespDepth),
    .CntW  (CntW)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rstN  (rst_ni),
    .i_push  (r_inflight),
    .i_entry (w_pushEntry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_dValid = (w_count != '0);
  assign w_pop    = w_dValid && tl_i.d_ready;

  // D channel shows the buffer head; every field is held at zero while nothing is valid.
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = w_aReady;
    if (w_dValid) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = w_head.opcode;
      tl_o.d_size   = w_head.size;
      tl_o.d_source = w_head.source;
      tl_o.d_data   = w_head.data;
      tl_o.d_error  = w_head.error;
    end
  end

endmodule

// File: tb/tb_tlul_sram_resp.sv
// Directed self-checking bench for tlul_sram_resp with a zero-initialised SRAM model.
// Honours TLUL_SRAM_RESP_RANGE_ERR_EN to select the expected out-of-range behaviour.
module tb_tlul_sram_resp;
  import tlul_sram_resp_pkg::*;

  logic        clk;
  logic        rstN;
  tl_h2d_t     tlIn;
  tl_d2h_t     tlOut;
  logic        req;
  logic        we;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic [31:0] mem [1024];

  int checks = 0;
  int passes = 0;

  tlul_sram_resp #(
    .Depth     (1024),
    .AddrWidth (10),
    .RespDepth (2)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .tl_i    (tlIn),
    .tl_o    (tlOut),
    .req_o   (req),
    .we_o    (we),
    .addr_o  (addr),
    .wdata_o (wdata),
    .wmask_o (wmask),
    .rdata_i (rdata)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM model: masked write, or read data one cycle later.
  always @(posedge clk) begin
    if (req === 1'b1) begin
      if (we === 1'b1) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
      else             rdata <= mem[addr];
    end
  end

  task automatic driveA(input logic [2:0] op, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] msk, input logic [7:0] src);
    tlIn.a_valid   = 1'b1;
    tlIn.a_opcode  = op;
    tlIn.a_param   = 3'd0;
    tlIn.a_size    = 2'd2;
    tlIn.a_source  = src;
    tlIn.a_address = adr;
    tlIn.a_mask    = msk;
    tlIn.a_data    = dat;
    tlIn.a_user    = '0;
  endtask

  task automatic idleA();
    tlIn.a_valid = 1'b0;
  endtask

  // Present a request, hold it until a_ready, and return one cycle after the accept edge.
  task automatic sendA(input logic [2:0] op, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] msk, input logic [7:0] src, output bit ok);
    driveA(op, adr, dat, msk, src);
    #1;
    for (int i = 0; i < 20 && tlOut.a_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    ok = (tlOut.a_ready === 1'b1);
    @(posedge clk); #1;
    idleA();
  endtask

  task automatic waitDValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tlOut.d_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tlIn.d_ready = 1'b1;
    driveA(OpGet, 32'd0, 32'd0, 4'hF, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tlOut.a_ready !== 1'b0) $display("[TB] FAIL reset_a_ready: got %b expected 0", tlOut.a_ready); else passes++;
    checks++; if (tlOut !== '0) $display("[TB] FAIL reset_tl_o: got %h expected 0", tlOut); else passes++;
    checks++; if (req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", req); else passes++;
    idleA();
    rstN = 1'b1;
    @(posedge clk); #1;
    checks++; if (tlOut.a_ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %b expected 1", tlOut.a_ready); else passes++;
  endtask

  task automatic test_put_full();
    bit ok;
    driveA(OpPutFullData, 32'd100, 32'd100, 4'hF, 8'h11);
    #1;
    checks++; if (req !== 1'b1) $display("[TB] FAIL put_req: got %b expected 1", req); else passes++;
    checks++; if (we !== 1'b1) $display("[TB] FAIL put_we: got %b expected 1", we); else passes++;
    checks++; if (addr !== 10'd25) $display("[TB] FAIL put_addr: got %0d expected 25", addr); else passes++;
    checks++; if (wmask !== 32'hFFFF_FFFF) $display("[TB] FAIL put_wmask: got %h expected ffffffff", wmask); else passes++;
    checks++; if (wdata !== 32'd100) $display("[TB] FAIL put_wdata: got %0d expected 100", wdata); else passes++;
    @(posedge clk); #1;
    idleA();
    waitDValid(ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL put_resp_timeout: got %b expected 1", ok); else passes++;
    checks++; if (tlOut.d_opcode !== OpAccessAck) $display("[TB] FAIL put_opcode: got %0d expected 0", tlOut.d_opcode); else passes++;
    checks++; if (tlOut.d_error !== 1'b0) $display("[TB] FAIL put_error: got %b expected 0", tlOut.d_error); else passes++;
    checks++; if (tlOut.d_source !== 8'h11) $display("[TB] FAIL put_source: got %h expected 11", tlOut.d_source); else passes++;
    checks++; if (tlOut.d_size !== 2'd2) $display("[TB] FAIL put_size: got %0d expected 2", tlOut.d_size); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_get();
    bit ok;
    sendA(OpGet, 32'd100, 32'd0, 4'hF, 8'h22, ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL get_accept: got %b expected 1", ok); else passes++;
    waitDValid(ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL get_resp_timeout: got %b expected 1", ok); else passes++;
    checks++; if (tlOut.d_opcode !== OpAccessAckData) $display("[TB] FAIL get_opcode: got %0d expected 1", tlOut.d_opcode); else passes++;
    checks++; if (tlOut.d_data !== 32'd100) $display("[TB] FAIL get_data: got %h expected 64", tlOut.d_data); else passes++;
    checks++; if (tlOut.d_source !== 8'h22) $display("[TB] FAIL get_source: got %h expected 22", tlOut.d_source); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_partial();
    bit ok;
    driveA(OpPutPartialData, 32'd200, 32'hAABB_CCDD, 4'b0101, 8'h05);
    #1;
    checks++; if (req !== 1'b1 || we !== 1'b1) $display("[TB] FAIL partial_req_we: got %b%b expected 11", req, we); else passes++;
    checks++; if (addr !== 10'd50) $display("[TB] FAIL partial_addr: got %0d expected 50", addr); else passes++;
    checks++; if (wmask !== 32'h00FF_00FF) $display("[TB] FAIL partial_wmask: got %h expected 00ff00ff", wmask); else passes++;
    @(posedge clk); #1;
    idleA();
    waitDValid(ok);
    @(posedge clk); #1;
    sendA(OpGet, 32'd200, 32'd0, 4'hF, 8'h06, ok);
    waitDValid(ok);
    checks++; if (tlOut.d_data !== 32'h00BB_00DD) $display("[TB] FAIL partial_readback: got %h expected 00bb00dd", tlOut.d_data); else passes++;
    @(posedge clk); #1;
    // An all-zero byte mask still strobes the SRAM but must leave the word untouched.
    driveA(OpPutPartialData, 32'd300, 32'hFFFF_FFFF, 4'b0000, 8'h07);
    #1;
    checks++; if (req !== 1'b1) $display("[TB] FAIL zero_mask_req: got %b expected 1", req); else passes++;
    checks++; if (wmask !== 32'h0) $display("[TB] FAIL zero_mask_wmask: got %h expected 0", wmask); else passes++;
    @(posedge clk); #1;
    idleA();
    waitDValid(ok);
    @(posedge clk); #1;
    sendA(OpGet, 32'd300, 32'd0, 4'hF, 8'h08, ok);
    waitDValid(ok);
    checks++; if (tlOut.d_data !== 32'h0) $display("[TB] FAIL zero_mask_readback: got %h expected 0", tlOut.d_data); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_unsupported();
    bit ok;
    driveA(3'd2, 32'd100, 32'd0, 4'hF, 8'h09);
    #1;
    checks++; if (req !== 1'b0) $display("[TB] FAIL unsup_req: got %b expected 0", req); else passes++;
    @(posedge clk); #1;
    idleA();
    waitDValid(ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL unsup_resp_timeout: got %b expected 1", ok); else passes++;
    checks++; if (tlOut.d_error !== 1'b1) $display("[TB] FAIL unsup_error: got %b expected 1", tlOut.d_error); else passes++;
    checks++; if (tlOut.d_opcode !== OpAccessAck) $display("[TB] FAIL unsup_opcode: got %0d expected 0", tlOut.d_opcode); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [3] = '{32'd100, 32'd200, 32'd100};
    logic [7:0]  srcs [3] = '{8'h31, 8'h32, 8'h33};
    logic [31:0] exps [3] = '{32'd100, 32'h00BB_00DD, 32'd100};
    int issued = 0;
    bit acc;
    bit ok;
    tlIn.d_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (issued < 3) driveA(OpGet, adrs[issued], 32'd0, 4'hF, srcs[issued]);
      else            idleA();
      #1;
      acc = (tlIn.a_valid === 1'b1) && (tlOut.a_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) issued++;
    end
    idleA();
    checks++; if (issued != 2) $display("[TB] FAIL bp_accepted: got %0d expected 2", issued); else passes++;
    checks++; if (tlOut.a_ready !== 1'b0) $display("[TB] FAIL bp_a_ready: got %b expected 0", tlOut.a_ready); else passes++;
    checks++; if (tlOut.d_valid !== 1'b1) $display("[TB] FAIL bp_d_valid: got %b expected 1", tlOut.d_valid); else passes++;
    tlIn.d_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      waitDValid(ok);
      checks++; if (tlOut.d_data !== exps[k]) $display("[TB] FAIL bp_data%0d: got %h expected %h", k, tlOut.d_data, exps[k]); else passes++;
      checks++; if (tlOut.d_source !== srcs[k]) $display("[TB] FAIL bp_source%0d: got %h expected %h", k, tlOut.d_source, srcs[k]); else passes++;
      @(posedge clk); #1;
    end
    checks++; if (tlOut.d_valid !== 1'b0) $display("[TB] FAIL bp_drained: got %b expected 0", tlOut.d_valid); else passes++;
    sendA(OpGet, adrs[2], 32'd0, 4'hF, srcs[2], ok);
    waitDValid(ok);
    checks++; if (tlOut.d_data !== exps[2] || tlOut.d_source !== srcs[2]) $display("[TB] FAIL bp_third: got %h/%h expected %h/%h", tlOut.d_data, tlOut.d_source, exps[2], srcs[2]); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit sawValid = 1'b0;
    tlIn.d_ready = 1'b0;
    sendA(OpGet, 32'd100, 32'd0, 4'hF, 8'h44, ok);
    waitDValid(ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL rstmid_pending: got %b expected 1", ok); else passes++;
    rstN = 1'b0;
    @(posedge clk); #1;
    checks++; if (tlOut.d_valid !== 1'b0) $display("[TB] FAIL rstmid_d_valid: got %b expected 0", tlOut.d_valid); else passes++;
    checks++; if (tlOut !== '0) $display("[TB] FAIL rstmid_tl_o: got %h expected 0", tlOut); else passes++;
    rstN = 1'b1;
    tlIn.d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (tlOut.d_valid === 1'b1) sawValid = 1'b1;
    end
    checks++; if (sawValid !== 1'b0) $display("[TB] FAIL rstmid_stale: got %b expected 0", sawValid); else passes++;
    checks++; if (tlOut.a_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b expected 1", tlOut.a_ready); else passes++;
  endtask

  task automatic test_range();
    bit ok;
    sendA(OpPutFullData, 32'd0, 32'h1234_5678, 4'hF, 8'h50, ok);
    waitDValid(ok);
    @(posedge clk); #1;
    driveA(OpGet, 32'h0000_1000, 32'd0, 4'hF, 8'h51);
    #1;
`ifdef TLUL_SRAM_RESP_RANGE_ERR_EN
    checks++; if (req !== 1'b0) $display("[TB] FAIL range_req: got %b expected 0", req); else passes++;
    @(posedge clk); #1;
    idleA();
    waitDValid(ok);
    checks++; if (tlOut.d_error !== 1'b1) $display("[TB] FAIL range_error: got %b expected 1", tlOut.d_error); else passes++;
    checks++; if (tlOut.d_data !== 32'hFFFF_FFFF) $display("[TB] FAIL range_data: got %h expected ffffffff", tlOut.d_data); else passes++;
`else
    checks++; if (req !== 1'b1 || addr !== 10'd0) $display("[TB] FAIL alias_req_addr: got %b/%0d expected 1/0", req, addr); else passes++;
    @(posedge clk); #1;
    idleA();
    waitDValid(ok);
    checks++; if (tlOut.d_error !== 1'b0) $display("[TB] FAIL alias_error: got %b expected 0", tlOut.d_error); else passes++;
    checks++; if (tlOut.d_data !== 32'h1234_5678) $display("[TB] FAIL alias_data: got %h expected 12345678", tlOut.d_data); else passes++;
`endif
    @(posedge clk); #1;
  endtask

  // Run every scenario in order, then report.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    tlIn = '0;
    rstN = 1'b0;
    test_reset();
    test_put_full();
    test_get();
    test_partial();
    test_unsupported();
    test_back_to_back();
    test_reset_mid();
    test_range();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
